ili9341_spi_controller: RTL and testbench

ILI9341_SPI_CONTROLLER -- requirements
Module: ili9341_spi_controller

---
 rtl/ili9341_pkg.sv | 72 +++++++
 rtl/ili9341_delay_timer.sv | 30 +++
 rtl/ili9341_spi_controller.sv | 208 ++++++++++++++++++++
 tb/tb_ili9341_spi_controller.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/ili9341_pkg.sv
// Shared ILI9341 definitions: opcodes, D/C levels, FSM types and the init ROM.
package ili9341_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_RDDST   = 8'h09;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam logic [7:0] MADCTL_VAL  = 8'h28;
  localparam logic [7:0] COLMOD_VAL  = 8'h55;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  // Step indices that change the flow after their transfer completes
  localparam logic [4:0] STEP_SWRESET = 5'd0;
  localparam logic [4:0] STEP_SLPOUT  = 5'd1;
  localparam logic [4:0] STEP_RDDST   = 5'd7;
  localparam logic [4:0] STEP_CASET   = 5'd8;
  localparam logic [4:0] STEP_RAMWR   = 5'd18;

  typedef enum logic [3:0] {
    HW_RST_HOLD, HW_RST_WAIT, SEND, WAIT_BUSY_HI, WAIT_BUSY_LO,
    DELAY, READ_STATUS, MEM_REQ, MEM_WAIT, PIXEL
  } state_t;

  typedef enum logic [1:0] { MODE_INIT, MODE_READ, MODE_PIXEL } mode_t;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } spi_word_t;

  function automatic int unsigned at_least4(input int unsigned v);
    return (v > 4) ? v : 4;
  endfunction

  // Byte and D/C level emitted at each init step
  function automatic spi_word_t init_rom(input logic [4:0] step,
                                         input logic [15:0] dx,
                                         input logic [15:0] dy);
    spi_word_t w;
    case (step)
      5'd0:    w = {DC_CMD,  CMD_SWRESET};
      5'd1:    w = {DC_CMD,  CMD_SLPOUT};
      5'd2:    w = {DC_CMD,  CMD_MADCTL};
      5'd3:    w = {DC_DATA, MADCTL_VAL};
      5'd4:    w = {DC_CMD,  CMD_COLMOD};
      5'd5:    w = {DC_DATA, COLMOD_VAL};
      5'd6:    w = {DC_CMD,  CMD_DISPON};
      5'd7:    w = {DC_CMD,  CMD_RDDST};
      5'd8:    w = {DC_CMD,  CMD_CASET};
      5'd9:    w = {DC_DATA, 8'h00};
      5'd10:   w = {DC_DATA, 8'h00};
      5'd11:   w = {DC_DATA, dx[15:8]};
      5'd12:   w = {DC_DATA, dx[7:0]};
      5'd13:   w = {DC_CMD,  CMD_PASET};
      5'd14:   w = {DC_DATA, 8'h00};
      5'd15:   w = {DC_DATA, 8'h00};
      5'd16:   w = {DC_DATA, dy[15:8]};
      5'd17:   w = {DC_DATA, dy[7:0]};
      default: w = {DC_CMD,  CMD_RAMWR};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/ili9341_delay_timer.sv
// Loadable down-counter; done is high while the count is zero.
module ili9341_delay_timer
  import ili9341_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count,
  output logic         done
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise decrement toward zero while enabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/ili9341_spi_controller.sv
// ILI9341 bring-up, status readback and endless frame-buffer streaming over SPI.
module ili9341_spi_controller
  import ili9341_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 12000000,
  parameter int DISPLAY_X    = 320,
  parameter int DISPLAY_Y    = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_busy,
  input  logic [7:0]  spi_in,
  input  logic [7:0]  mem_in,
  input  logic        mem_ready,
  output logic        dis_reset,
  output logic        dc,
  output logic        spi_start,
  output logic [7:0]  spi_out,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic [31:0] display_status
);

  localparam int unsigned HOLD = at_least4(SYS_CLK_FREQ / 100000);
  localparam int unsigned REL  = at_least4(SYS_CLK_FREQ / 200);
  localparam int unsigned SWR  = at_least4(SYS_CLK_FREQ / 200);
  localparam int unsigned SLP  = at_least4(SYS_CLK_FREQ / 8);
  localparam logic [31:0] LAST_ADDR = 32'(DISPLAY_X * DISPLAY_Y * 2 - 1);

  state_t      state_q;
  mode_t       mode_q;
  logic [4:0]  step_q;
  logic [2:0]  rd_cnt_q;
  logic        dis_reset_q, dc_q, spi_start_q, mem_req_q;
  logic [7:0]  spi_out_q;
  logic [31:0] mem_addr_q, status_q;
  logic        tmr_load, tmr_count, tmr_done;
  logic [31:0] tmr_val;
  spi_word_t   rom_word;

  assign rom_word = init_rom(step_q, 16'(DISPLAY_X), 16'(DISPLAY_Y));

  ili9341_delay_timer #(.W(32)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_count),
    .done     (tmr_done)
  );

  // Timer load/enable decoded from the same conditions the FSM branches on
  always_comb begin
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_count = 1'b0;
    case (state_q)
      HW_RST_HOLD: begin
        tmr_count = 1'b1;
        if (dis_reset_q) begin
          tmr_load = 1'b1;
          tmr_val  = 32'(HOLD - 1);   // low phase starts this cycle
        end else if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = 32'(REL);
        end
      end
      HW_RST_WAIT, DELAY: tmr_count = 1'b1;
      WAIT_BUSY_LO: begin
        if (!spi_busy && (mode_q == MODE_INIT)) begin
          if (step_q == STEP_SWRESET) begin
            tmr_load = 1'b1;
            tmr_val  = 32'(SWR);
          end else if (step_q == STEP_SLPOUT) begin
            tmr_load = 1'b1;
            tmr_val  = 32'(SLP);
          end
        end
      end
      default: ;
    endcase
  end

  // Main sequencer: reset pulse, init ROM, status read, pixel streaming
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= HW_RST_HOLD;
      mode_q      <= MODE_INIT;
      step_q      <= '0;
      rd_cnt_q    <= '0;
      dis_reset_q <= 1'b1;
      dc_q        <= DC_CMD;
      spi_start_q <= 1'b0;
      spi_out_q   <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      status_q    <= '0;
    end else begin
      spi_start_q <= 1'b0;
      mem_req_q   <= 1'b0;
      case (state_q)
        HW_RST_HOLD: begin
          if (dis_reset_q) begin
            dis_reset_q <= 1'b0;
          end else if (tmr_done) begin
            dis_reset_q <= 1'b1;
            state_q     <= HW_RST_WAIT;
          end
        end
        HW_RST_WAIT: if (tmr_done) state_q <= SEND;
        SEND: begin
          if (!spi_busy) begin
            dc_q        <= rom_word.dc;
            spi_out_q   <= rom_word.data;
            spi_start_q <= 1'b1;
            state_q     <= WAIT_BUSY_HI;
          end
        end
        WAIT_BUSY_HI: if (spi_busy) state_q <= WAIT_BUSY_LO;
        WAIT_BUSY_LO: begin
          if (!spi_busy) begin
            case (mode_q)
              MODE_READ: begin
                // First received byte is the dummy cycle and is dropped
                if (rd_cnt_q != 3'd0) status_q <= {status_q[23:0], spi_in};
                if (rd_cnt_q == 3'd4) begin
                  mode_q  <= MODE_INIT;
                  step_q  <= STEP_CASET;
                  state_q <= SEND;
                end else begin
                  rd_cnt_q <= rd_cnt_q + 3'd1;
                  state_q  <= READ_STATUS;
                end
              end
              MODE_PIXEL: begin
                if (mem_addr_q == LAST_ADDR) begin
                  mem_addr_q <= '0;
                  mode_q     <= MODE_INIT;
                  step_q     <= STEP_RAMWR;
                  state_q    <= SEND;
                end else begin
                  mem_addr_q <= mem_addr_q + 32'd1;
                  state_q    <= MEM_REQ;
                end
              end
              default: begin
                if ((step_q == STEP_SWRESET) || (step_q == STEP_SLPOUT)) begin
                  state_q <= DELAY;
                end else if (step_q == STEP_RDDST) begin
                  mode_q   <= MODE_READ;
                  rd_cnt_q <= '0;
                  state_q  <= READ_STATUS;
                end else if (step_q == STEP_RAMWR) begin
                  mode_q  <= MODE_PIXEL;
                  state_q <= MEM_REQ;
                end else begin
                  step_q  <= step_q + 5'd1;
                  state_q <= SEND;
                end
              end
            endcase
          end
        end
        DELAY: begin
          if (tmr_done) begin
            step_q  <= step_q + 5'd1;
            state_q <= SEND;
          end
        end
        READ_STATUS: begin
          if (!spi_busy) begin
            dc_q        <= DC_DATA;
            spi_out_q   <= 8'h00;
            spi_start_q <= 1'b1;
            state_q     <= WAIT_BUSY_HI;
          end
        end
        MEM_REQ: begin
          mem_req_q <= 1'b1;
          state_q   <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            spi_out_q <= mem_in;
            dc_q      <= DC_DATA;
            state_q   <= PIXEL;
          end
        end
        PIXEL: begin
          if (!spi_busy) begin
            spi_start_q <= 1'b1;
            state_q     <= WAIT_BUSY_HI;
          end
        end
        default: state_q <= HW_RST_HOLD;
      endcase
    end
  end

  assign dis_reset      = dis_reset_q;
  assign dc             = dc_q;
  assign spi_start      = spi_start_q;
  assign spi_out        = spi_out_q;
  assign mem_addr       = mem_addr_q;
  assign mem_req        = mem_req_q;
  assign display_status = status_q;

endmodule

// File: tb/tb_ili9341_spi_controller.sv
// Directed bench: small display (3x4), 1 Hz clock parameter, 4-cycle SPI master.
module tb_ili9341_spi_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_busy;
  logic [7:0]  spi_in = 8'hAA;
  logic [7:0]  mem_in;
  logic        mem_ready;
  logic        dis_reset, dc, spi_start, mem_req;
  logic [7:0]  spi_out;
  logic [31:0] mem_addr, display_status;

  int checks = 0;
  int failures = 0;

  logic [7:0] rgb [6];
  logic [8:0] exp_seq [24];
  int         busy_cnt;

  always #5 clk = ~clk;

  ili9341_spi_controller #(
    .SYS_CLK_FREQ (1),
    .DISPLAY_X    (3),
    .DISPLAY_Y    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .spi_busy       (spi_busy),
    .spi_in         (spi_in),
    .mem_in         (mem_in),
    .mem_ready      (mem_ready),
    .dis_reset      (dis_reset),
    .dc             (dc),
    .spi_start      (spi_start),
    .spi_out        (spi_out),
    .mem_addr       (mem_addr),
    .mem_req        (mem_req),
    .display_status (display_status)
  );

  // SPI master model: busy rises the cycle after start and lasts 4 cycles
  always @(posedge clk or posedge reset) begin
    if (reset) busy_cnt <= 0;
    else if (spi_start && busy_cnt == 0) busy_cnt <= 4;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign spi_busy = (busy_cnt != 0);

  // Frame-buffer model: answers one cycle after the request
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_in    <= 8'h00;
    end else begin
      mem_ready <= mem_req;
      mem_in    <= rgb[int'(mem_addr % 32'd6)];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next spi_start pulse; gap counts negedges since the call
  task automatic get_start(output int gap);
    gap = 0;
    @(negedge clk);
    gap = 1;
    while (spi_start !== 1'b1 && gap < 400) begin
      @(negedge clk);
      gap++;
    end
    if (spi_start !== 1'b1) check("start_timeout", 32'(spi_start), 32'd1);
  endtask

  task automatic measure_reset_low(input string tag);
    int low;
    low = 0;
    @(negedge clk);
    while (dis_reset === 1'b0 && low < 50) begin
      low++;
      @(negedge clk);
    end
    check(tag, 32'(low), 32'd4);
  endtask

  initial begin
    int gap;
    int n;
    rgb = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
    exp_seq = '{9'h001, 9'h011, 9'h036, 9'h128, 9'h03A, 9'h155, 9'h029, 9'h009,
                9'h100, 9'h100, 9'h100, 9'h100, 9'h100,
                9'h02A, 9'h100, 9'h100, 9'h100, 9'h103,
                9'h02B, 9'h100, 9'h100, 9'h100, 9'h104, 9'h02C};

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_dis_reset", 32'(dis_reset), 32'd1);
    check("rst_dc", 32'(dc), 32'd0);
    check("rst_spi_start", 32'(spi_start), 32'd0);
    check("rst_spi_out", 32'(spi_out), 32'h00);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_status", display_status, 32'd0);

    reset = 1'b0;
    measure_reset_low("dis_reset_low_cycles");

    // Init, status read and window setup
    for (int i = 0; i < 24; i++) begin
      get_start(gap);
      check($sformatf("seq%0d_dc", i + 1), 32'(dc), 32'(exp_seq[i][8]));
      check($sformatf("seq%0d_byte", i + 1), 32'(spi_out), 32'(exp_seq[i][7:0]));
      if (i < 3) check($sformatf("seq%0d_gap_gt4", i + 1), 32'(gap > 4), 32'd1);
      else check($sformatf("seq%0d_gap_gt1", i + 1), 32'(gap > 1), 32'd1);
      if (i == 8)  check("status_before_read", display_status, 32'h0);
      if (i == 12) check("status_three_bytes", display_status, 32'h00AAAAAA);
      if (i == 13) check("status_at_caset", display_status, 32'hAAAAAAAA);
    end

    // Full frame of 3*4*2 bytes
    for (int i = 0; i < 24; i++) begin
      get_start(gap);
      check($sformatf("pix%0d_dc", i), 32'(dc), 32'd1);
      check($sformatf("pix%0d_byte", i), 32'(spi_out), 32'(rgb[i % 6]));
      check($sformatf("pix%0d_addr", i), mem_addr, 32'(i));
    end

    // Wrap: RAMWR again, then streaming restarts at address 0
    get_start(gap);
    check("wrap_dc", 32'(dc), 32'd0);
    check("wrap_byte", 32'(spi_out), 32'h2C);
    check("wrap_addr", mem_addr, 32'd0);
    for (int i = 0; i < 2; i++) begin
      get_start(gap);
      check($sformatf("wrap_pix%0d_byte", i), 32'(spi_out), 32'(rgb[i]));
      check($sformatf("wrap_pix%0d_addr", i), mem_addr, 32'(i));
    end

    // Reset in the middle of a pixel transfer restarts everything
    n = 0;
    while (spi_busy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("midreset_busy_seen", 32'(spi_busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_dis_reset", 32'(dis_reset), 32'd1);
    check("midreset_mem_addr", mem_addr, 32'd0);
    check("midreset_status", display_status, 32'd0);
    check("midreset_spi_out", 32'(spi_out), 32'h00);
    check("midreset_dc", 32'(dc), 32'd0);
    reset = 1'b0;
    measure_reset_low("midreset_low_cycles");
    get_start(gap);
    check("restart_dc", 32'(dc), 32'd0);
    check("restart_byte", 32'(spi_out), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
